// File: rtl/if_id_ctrl_if.sv
// IF/ID boundary bundle: fetch-side beat, decode-side beat, redirect and
// EX-stage load information. The master modport is the surrounding pipeline,
// the slave modport is the if_id_ctrl controller.
interface if_id_ctrl_if #(
  parameter int XLEN = 64
);
  logic            if_valid;
  logic            if_ready;
  logic [31:0]     if_inst;
  logic [XLEN-1:0] if_pc;

  logic            id_valid;
  logic            id_ready;
  logic [31:0]     id_inst;
  logic [XLEN-1:0] id_pc;
  logic [6:0]      id_opcode;
  logic [4:0]      id_rd;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;

  logic            flush;
  logic            ex_load_valid;
  logic [4:0]      ex_rd;

  modport master (
    output if_valid, if_inst, if_pc, id_ready, flush, ex_load_valid, ex_rd,
    input  if_ready, id_valid, id_inst, id_pc, id_opcode, id_rd, id_rs1, id_rs2
  );

  modport slave (
    input  if_valid, if_inst, if_pc, id_ready, flush, ex_load_valid, ex_rd,
    output if_ready, id_valid, id_inst, id_pc, id_opcode, id_rd, id_rs1, id_rs2
  );
endinterface

// File: rtl/if_id_ctrl.sv
// IF->ID pipeline register controller: one-entry instruction/PC holding
// stage with valid/ready on both sides, load-use bubble insertion against
// the EX stage and synchronous flush on redirect.
// Optional macro IF_ID_CTRL_PERF_EN adds saturating bubble/flush counters.
//
// state | meaning
// EMPTY | nothing held, id_inst shows NOP_INST, fetch beats accepted
// FULL  | instruction held and presented (unless a load-use hazard masks it)
// STALL | remaining load-use bubbles being counted down, no transfers
module if_id_ctrl #(
  parameter int          XLEN     = 64,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          LOAD_LAT = 1,
  parameter int          PERF_W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  if_id_ctrl_if.slave     bus
`ifdef IF_ID_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_bubble_cnt,
  output logic [PERF_W-1:0] perf_flush_cnt
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 7 || PERF_W < 1) begin : g_param_check
    $error("if_id_ctrl: LOAD_LAT must be 1..7 and PERF_W at least 1");
  end

  typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;

  state_t          state;
  logic [2:0]      bub_cnt;
  logic [31:0]     inst_q;
  logic [XLEN-1:0] pc_q;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       id_valid;
  logic       id_fire;
  logic       if_ready;
  logic       if_fire;

  assign opcode = inst_q[6:0];
  assign rs1    = inst_q[19:15];
  assign rs2    = inst_q[24:20];

  // LUI, AUIPC and JAL carry no rs1; only R-type, R-type-W, stores and
  // branches read rs2.
  assign use_rs1 = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign use_rs2 = opcode inside {7'b0110011, 7'b0111011, 7'b0100011, 7'b1100011};

  assign hazard = (state == FULL) && bus.ex_load_valid && (bus.ex_rd != 5'd0) &&
                  ((use_rs1 && (rs1 == bus.ex_rd)) || (use_rs2 && (rs2 == bus.ex_rd)));

  assign id_valid = (state == FULL) && !hazard && !bus.flush;
  assign id_fire  = id_valid && bus.id_ready;
  // rst gates if_ready so no beat is advertised while the block is held in reset.
  assign if_ready = rst && !bus.flush && ((state == EMPTY) || ((state == FULL) && id_fire));
  assign if_fire  = bus.if_valid && if_ready;

  assign bus.id_valid  = id_valid;
  assign bus.if_ready  = if_ready;
  assign bus.id_inst   = inst_q;
  assign bus.id_pc     = pc_q;
  assign bus.id_opcode = inst_q[6:0];
  assign bus.id_rd     = inst_q[11:7];
  assign bus.id_rs1    = inst_q[19:15];
  assign bus.id_rs2    = inst_q[24:20];

  // Holding-stage FSM: flush first, then hazard/stall, then handshake moves.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      bub_cnt <= 3'd0;
      inst_q  <= NOP_INST;
      pc_q    <= '0;
    end else if (bus.flush) begin
      state   <= EMPTY;
      bub_cnt <= 3'd0;
      inst_q  <= NOP_INST;
    end else begin
      case (state)
        EMPTY: begin
          if (if_fire) begin
            state  <= FULL;
            inst_q <= bus.if_inst;
            pc_q   <= bus.if_pc;
          end
        end
        FULL: begin
          if (hazard) begin
            // With a single-cycle load latency the hazard cycle itself is the
            // whole bubble, so stay in FULL and re-check next cycle.
            state   <= (LOAD_LAT == 1) ? FULL : STALL;
            bub_cnt <= 3'(LOAD_LAT - 1);
          end else if (id_fire) begin
            if (if_fire) begin
              inst_q <= bus.if_inst;
              pc_q   <= bus.if_pc;
            end else begin
              state  <= EMPTY;
              inst_q <= NOP_INST;
            end
          end
        end
        STALL: begin
          bub_cnt <= bub_cnt - 3'd1;
          if (bub_cnt == 3'd1) begin
            state <= FULL;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

`ifdef IF_ID_CTRL_PERF_EN
  // Saturating event counters for bubble cycles and flushes of a live stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if ((hazard || (state == STALL)) && (perf_bubble_cnt != '1)) begin
        perf_bubble_cnt <= perf_bubble_cnt + 1'b1;
      end
      if (bus.flush && (state != EMPTY) && (perf_flush_cnt != '1)) begin
        perf_flush_cnt <= perf_flush_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_ctrl.sv
// Bench for if_id_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one
// directed stimulus stream; a per-instance occupancy/bubble-debt model is
// compared on every falling edge, plus hand-computed literal checks.
module tb_if_id_ctrl;
  localparam int          XLEN = 64;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic            if_valid = 1'b0;
  logic [31:0]     if_inst  = '0;
  logic [XLEN-1:0] if_pc    = '0;
  logic            id_ready = 1'b0;
  logic            flush    = 1'b0;
  logic            ex_load_valid = 1'b0;
  logic [4:0]      ex_rd    = '0;

  if_id_ctrl_if #(.XLEN(XLEN)) bus_a ();
  if_id_ctrl_if #(.XLEN(XLEN)) bus_b ();

  assign bus_a.if_valid = if_valid;      assign bus_b.if_valid = if_valid;
  assign bus_a.if_inst  = if_inst;       assign bus_b.if_inst  = if_inst;
  assign bus_a.if_pc    = if_pc;         assign bus_b.if_pc    = if_pc;
  assign bus_a.id_ready = id_ready;      assign bus_b.id_ready = id_ready;
  assign bus_a.flush    = flush;         assign bus_b.flush    = flush;
  assign bus_a.ex_load_valid = ex_load_valid;
  assign bus_b.ex_load_valid = ex_load_valid;
  assign bus_a.ex_rd    = ex_rd;         assign bus_b.ex_rd    = ex_rd;

`ifdef IF_ID_CTRL_PERF_EN
  logic [31:0] pb_a, pf_a, pb_b, pf_b;
`endif

  if_id_ctrl #(.XLEN(XLEN), .NOP_INST(NOP), .LOAD_LAT(1), .PERF_W(32)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
`ifdef IF_ID_CTRL_PERF_EN
    , .perf_bubble_cnt(pb_a), .perf_flush_cnt(pf_a)
`endif
  );

  if_id_ctrl #(.XLEN(XLEN), .NOP_INST(NOP), .LOAD_LAT(3), .PERF_W(32)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
`ifdef IF_ID_CTRL_PERF_EN
    , .perf_bubble_cnt(pb_b), .perf_flush_cnt(pf_b)
`endif
  );

  logic            o_valid [2];
  logic            o_ready [2];
  logic [31:0]     o_inst  [2];
  logic [XLEN-1:0] o_pc    [2];
  logic [6:0]      o_opc   [2];
  logic [4:0]      o_rd    [2];
  logic [4:0]      o_rs1   [2];
  logic [4:0]      o_rs2   [2];
  assign o_valid[0] = bus_a.id_valid;  assign o_valid[1] = bus_b.id_valid;
  assign o_ready[0] = bus_a.if_ready;  assign o_ready[1] = bus_b.if_ready;
  assign o_inst[0]  = bus_a.id_inst;   assign o_inst[1]  = bus_b.id_inst;
  assign o_pc[0]    = bus_a.id_pc;     assign o_pc[1]    = bus_b.id_pc;
  assign o_opc[0]   = bus_a.id_opcode; assign o_opc[1]   = bus_b.id_opcode;
  assign o_rd[0]    = bus_a.id_rd;     assign o_rd[1]    = bus_b.id_rd;
  assign o_rs1[0]   = bus_a.id_rs1;    assign o_rs1[1]   = bus_b.id_rs1;
  assign o_rs2[0]   = bus_a.id_rs2;    assign o_rs2[1]   = bus_b.id_rs2;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: is an instruction held, what it is, and how many bubble
  // cycles are still owed after the hazard cycle itself.
  logic            m_occ  [2];
  logic [31:0]     m_inst [2];
  logic [XLEN-1:0] m_pc   [2];
  int              m_owed [2];
  int              m_pb   [2];
  int              m_pf   [2];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic bit reads_reg(input logic [31:0] inst, input logic [4:0] r);
    logic [6:0] op;
    bit r1, r2;
    op = inst[6:0];
    r1 = !(op inside {7'h37, 7'h17, 7'h6f});
    r2 = op inside {7'h33, 7'h3b, 7'h23, 7'h63};
    return (r != 5'd0) && ((r1 && inst[19:15] == r) || (r2 && inst[24:20] == r));
  endfunction

  function automatic bit m_hazard(input int k);
    return m_occ[k] && (m_owed[k] == 0) && ex_load_valid && reads_reg(m_inst[k], ex_rd);
  endfunction

  function automatic bit m_valid(input int k);
    return m_occ[k] && (m_owed[k] == 0) && !m_hazard(k) && !flush;
  endfunction

  function automatic bit m_ready(input int k);
    return rst && !flush && (!m_occ[k] || (m_valid(k) && id_ready));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_occ[k] = 1'b0; m_inst[k] = NOP; m_pc[k] = '0;
        m_owed[k] = 0; m_pb[k] = 0; m_pf[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit hz, v, r;
        hz = m_hazard(k);
        v  = m_valid(k);
        r  = m_ready(k);
        if (hz || m_owed[k] > 0) m_pb[k]++;
        if (flush && m_occ[k]) m_pf[k]++;
        if (flush) begin
          m_occ[k] = 1'b0; m_inst[k] = NOP; m_owed[k] = 0;
        end else if (m_owed[k] > 0) begin
          m_owed[k]--;
        end else if (hz) begin
          m_owed[k] = lat_of(k) - 1;
        end else if (v && id_ready) begin
          if (if_valid) begin
            m_inst[k] = if_inst; m_pc[k] = if_pc;
          end else begin
            m_occ[k] = 1'b0; m_inst[k] = NOP;
          end
        end else if (!m_occ[k] && if_valid && r) begin
          m_occ[k] = 1'b1; m_inst[k] = if_inst; m_pc[k] = if_pc;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("id_valid[%0d]", k), 64'(o_valid[k]), 64'(m_valid(k)));
      chk($sformatf("if_ready[%0d]", k), 64'(o_ready[k]), 64'(m_ready(k)));
      chk($sformatf("id_inst[%0d]", k),  64'(o_inst[k]),  64'(m_inst[k]));
      chk($sformatf("id_pc[%0d]", k),    o_pc[k],         m_pc[k]);
      chk($sformatf("id_opcode[%0d]", k), 64'(o_opc[k]), 64'(m_inst[k][6:0]));
      chk($sformatf("id_rd[%0d]", k),    64'(o_rd[k]),  64'(m_inst[k][11:7]));
      chk($sformatf("id_rs1[%0d]", k),   64'(o_rs1[k]), 64'(m_inst[k][19:15]));
      chk($sformatf("id_rs2[%0d]", k),   64'(o_rs2[k]), 64'(m_inst[k][24:20]));
    end
`ifdef IF_ID_CTRL_PERF_EN
    chk("perf_bubble[0]", 64'(pb_a), 64'(m_pb[0]));
    chk("perf_bubble[1]", 64'(pb_b), 64'(m_pb[1]));
    chk("perf_flush[0]",  64'(pf_a), 64'(m_pf[0]));
    chk("perf_flush[1]",  64'(pf_b), 64'(m_pf[1]));
`endif
  end

  // ---------------- directed stimulus ----------------
  logic        s_valid [2];
  logic [31:0] s_inst  [2];

  task automatic drive(input bit v, input logic [31:0] inst, input logic [63:0] pc,
                       input bit rdy, input bit fl, input bit exl, input logic [4:0] exrd);
    if_valid = v; if_inst = inst; if_pc = pc; id_ready = rdy;
    flush = fl; ex_load_valid = exl; ex_rd = exrd;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      s_valid[k] = o_valid[k];
      s_inst[k]  = o_inst[k];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_valid[%0d]", tag, k), 64'(o_valid[k]), 64'd0);
      chk($sformatf("%s_ready[%0d]", tag, k), 64'(o_ready[k]), 64'd0);
      chk($sformatf("%s_inst[%0d]", tag, k),  64'(o_inst[k]),  64'(NOP));
      chk($sformatf("%s_pc[%0d]", tag, k),    o_pc[k],         64'd0);
    end
`ifdef IF_ID_CTRL_PERF_EN
    chk({tag, "_perf_b"}, 64'(pb_a) | 64'(pb_b), 64'd0);
    chk({tag, "_perf_f"}, 64'(pf_a) | 64'(pf_b), 64'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int          nxfer;
    int          bub [2];
    bit          seen [2];
    logic [31:0] t_inst [4];
    logic [4:0]  t_rd   [4];
    bit          t_val  [4];

    repeat (2) @(posedge clk);
    #1;
    chk_reset_values("reset");
    rst = 1'b1;

    // first beat, then four back-to-back beats
    drive(1'b1, 32'h0050_0093, 64'h8000_0000, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("first_rd[%0d]", k),  64'(o_rd[k]),  64'd1);
      chk($sformatf("first_opc[%0d]", k), 64'(o_opc[k]), 64'h13);
      chk($sformatf("first_pc[%0d]", k),  o_pc[k],       64'h8000_0000);
    end
    nxfer = 0;
    for (int i = 1; i <= 4; i++) begin
      logic [31:0] ins;
      ins = 32'h0000_0013 | (32'(i) << 7);
      drive(1'b1, ins, 64'h8000_0000 + 64'(4 * i), 1'b1, 1'b0, 1'b0, 5'd0);
      if (s_valid[0] && s_valid[1]) nxfer++;
    end
    chk("b2b_transfers", 64'(nxfer), 64'd4);
    chk("b2b_last_pc", o_pc[1], 64'h8000_0010);

    // decoder back-pressure for three cycles
    repeat (3) drive(1'b1, 32'h00a0_0293, 64'h8000_0014, 1'b0, 1'b0, 1'b0, 5'd0);
    chk("hold_pc", o_pc[0], 64'h8000_0010);
    chk("hold_inst", 64'(o_inst[1]), 64'h0000_0213);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("drain_valid", 64'(s_valid[0] & s_valid[1]), 64'd1);
    chk("drain_inst", 64'(o_inst[0]), 64'(NOP));

    // load-use on rs1 of add x2,x1,x2: 1 bubble (LOAD_LAT=1), 3 bubbles (LOAD_LAT=3)
    drive(1'b1, 32'h0020_8133, 64'h8000_0100, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int k = 0; k < 2; k++) begin bub[k] = 0; seen[k] = 1'b0; end
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, (i == 0), (i == 0) ? 5'd1 : 5'd0);
      for (int k = 0; k < 2; k++) begin
        if (!seen[k]) begin
          if (s_valid[k]) begin
            seen[k] = 1'b1;
            chk($sformatf("hazard_inst[%0d]", k), 64'(s_inst[k]), 64'h0020_8133);
          end else begin
            bub[k]++;
          end
        end
      end
    end
    chk("bubbles_lat1", 64'(bub[0]), 64'd1);
    chk("bubbles_lat3", 64'(bub[1]), 64'd3);

    // no-hazard cases and one rs2 hazard (store)
    t_inst[0] = 32'h0020_8133; t_rd[0] = 5'd0; t_val[0] = 1'b1;
    t_inst[1] = 32'h0000_82b7; t_rd[1] = 5'd1; t_val[1] = 1'b1;
    t_inst[2] = 32'h0010_0193; t_rd[2] = 5'd1; t_val[2] = 1'b1;
    t_inst[3] = 32'h0011_2023; t_rd[3] = 5'd1; t_val[3] = 1'b0;
    for (int t = 0; t < 4; t++) begin
      drive(1'b1, t_inst[t], 64'h8000_0180 + 64'(4 * t), 1'b1, 1'b0, 1'b0, 5'd0);
      drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1, t_rd[t]);
      chk($sformatf("nohaz_valid_a[%0d]", t), 64'(s_valid[0]), 64'(t_val[t]));
      chk($sformatf("nohaz_valid_b[%0d]", t), 64'(s_valid[1]), 64'(t_val[t]));
    end
    repeat (4) drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0);

    // flush while instance b is in STALL, with a fetch beat offered
    drive(1'b1, 32'h0020_8133, 64'h8000_0200, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1, 5'd1);
    drive(1'b1, 32'h0030_0193, 64'h8000_0204, 1'b1, 1'b1, 1'b0, 5'd0);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("flush_inst[%0d]", k), 64'(o_inst[k]), 64'(NOP));
      chk($sformatf("flush_pc[%0d]", k),   o_pc[k],        64'h8000_0200);
    end
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("post_flush_valid", 64'(s_valid[0] | s_valid[1]), 64'd0);

    // asynchronous reset in the middle of a stall
    drive(1'b1, 32'h0020_8133, 64'h8000_0300, 1'b1, 1'b0, 1'b0, 5'd0);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b1, 5'd1);
    #2 rst = 1'b0;
    #1;
    chk_reset_values("midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    drive(1'b1, 32'h0050_0093, 64'h8000_0400, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("after_rst_pc", o_pc[1], 64'h8000_0400);
    drive(1'b0, 32'h0, 64'h0, 1'b1, 1'b0, 1'b0, 5'd0);
    chk("after_rst_valid", 64'(s_valid[0] & s_valid[1]), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
- Controller for the IF→ID pipeline boundary: holds one fetched instruction and PC under a valid/ready handshake on both sides.
- Detects load-use hazards against the EX stage and inserts LOAD_LAT bubble cycles.
- Handles synchronous flush on redirect.
- Sits between the fetch unit and the decoder; its registered instruction feeds the decoder's opcode/rd/fun/rs1/rs2 field extraction.

Parameters:
- XLEN, 64, PC and datapath width
- NOP_INST, 32'h0000_0013, instruction value presented when empty, after reset and after flush
- LOAD_LAT, 1, bubble cycles per load-use hazard (legal 1..7)
- PERF_W, 32, performance counter width (used only with the optional feature)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_valid  in  1  fetch presents an instruction
- if_ready  out  1  controller accepts the fetch beat this cycle
- if_inst  in  32  fetched instruction
- if_pc  in  XLEN  fetched PC
- id_valid  out  1  decode-side beat valid
- id_ready  in  1  decoder/EX accepts the beat
- id_inst  out  32  registered instruction
- id_pc  out  XLEN  registered PC
- id_opcode  out  7  id_inst[6:0]
- id_rd  out  5  id_inst[11:7]
- id_rs1  out  5  id_inst[19:15]
- id_rs2  out  5  id_inst[24:20]
- flush  in  1  synchronous redirect; discard held and incoming instruction
- ex_load_valid  in  1  EX stage holds a load
- ex_rd  in  5  destination of that load

Behaviour:
- Reset (rst=0, async):
  - state=EMPTY, id_inst=NOP_INST, id_pc=0, bubble counter=0.
  - id_valid=0 and if_ready=0 while rst is low.
- Handshake definitions: if_fire = if_valid & if_ready; id_fire = id_valid & id_ready. Field outputs are pure slices of id_inst.
- States: EMPTY, FULL, STALL.
- Hazard (combinational):
  - hazard = FULL & ex_load_valid & (ex_rd≠0) & ((use_rs1 & id_rs1==ex_rd) | (use_rs2 & id_rs2==ex_rd)).
  - use_rs1 = opcode ∉ {0110111, 0010111, 1101111}.
  - use_rs2 = opcode ∈ {0110011, 0111011, 0100011, 1100011}.
- Output decode:
  - id_valid = FULL & ~hazard & ~flush.
  - if_ready = ~flush & (EMPTY | (FULL & id_fire)).
  - STALL never accepts a fetch beat.
- Flush (highest priority, any state):
  - Next state EMPTY, id_inst←NOP_INST, counter←0.
  - The incoming fetch beat is dropped (if_ready=0). id_pc is held.
- EMPTY: on if_fire → FULL; load id_inst/id_pc. Otherwise hold.
- FULL:
  - hazard: id_valid=0 this cycle, instruction held. If LOAD_LAT=1, next state is FULL and hazard is re-evaluated. Otherwise next state is STALL with counter←LOAD_LAT−1.
  - id_fire & if_fire → FULL, load new beat (back-to-back, zero bubble).
  - id_fire & ~if_valid → EMPTY, id_inst←NOP_INST.
  - ~id_fire → hold. id_inst/id_pc must remain stable while id_valid=1 and id_ready=0.
- STALL:
  - id_valid=0, counter decrements each cycle.
  - When counter=1 → FULL, where hazard is re-evaluated.
  - Total bubbles per hazard = LOAD_LAT.
- Latency: fetch beat to id_valid is 1 cycle. Throughput is 1 instr/cycle without hazards.
- Simultaneous events:
  - flush beats hazard, STALL and fetch.
  - hazard beats id_ready, so no transfer occurs.
  - ex_rd=0 never causes a hazard.
- Reset mid-STALL: immediate return to EMPTY, counter cleared.

Optional Feature:
- Macro IF_ID_CTRL_PERF_EN.
- Defined: adds outputs perf_bubble_cnt and perf_flush_cnt, each PERF_W bits, reset 0, saturating at all-ones.
  - perf_bubble_cnt increments on each cycle with hazard or STALL.
  - perf_flush_cnt increments on each cycle flush=1 while state≠EMPTY.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, if_valid=1, if_inst=32'h00500093, if_pc=64'h80000000, id_ready=1 → id_valid=1 next cycle, id_rd=1, id_opcode=7'h13; then 4 back-to-back beats transfer at 1/cycle.
- FULL with id_ready=0 for 3 cycles → id_inst/id_pc stable, if_ready=0; id_ready=1 → single transfer, no duplicate or lost beat.
- id_inst=32'h00208133 (add x2,x1,x2), ex_load_valid=1, ex_rd=1, LOAD_LAT=1 → exactly 1 cycle id_valid=0, then id_valid=1 with same instruction. LOAD_LAT=3 → 3 bubbles.
- Same instruction, ex_rd=0, or LUI with rd match on bits[19:15] → no bubble.
- flush=1 while STALL and if_valid=1 → next cycle EMPTY, id_valid=0, id_inst=32'h00000013, fetch beat not accepted.
- rst asserted mid-STALL (asynchronous, between edges) → outputs immediately reset values; with IF_ID_CTRL_PERF_EN, counters read 0.
